// File: rtl/axi4_stream_shift_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi4_stream_if
//   AXI4-Stream bundle used between the packet arbiter and its neighbours.
//
//   Signals : tvalid, tready, tdata, tkeep, tstrb, tlast, tid, tdest, tuser
//   Modports: master (drives payload, samples tready)
//             slave  (samples payload, drives tready)
// ---------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_shift_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_stream_shift_arbiter
//   Packet-level round-robin arbiter that shares one byte shifter among
//   NUM_SRC AXI4-Stream sources. One source is granted per packet; its beats
//   are passed combinationally to pkt_o, and its configured shift value is
//   captured at grant time and held on shift_o for the whole packet.
//
//   Ports:
//     clk_i        clock
//     rst_i        synchronous active-high reset
//     shift_cfg_i  per-source byte shift value (NUM_SRC x DATA_WIDTH_B_W)
//     pkt_i        source streams (slave side, array of NUM_SRC)
//     pkt_o        arbitrated stream towards the shifter (master side)
//     shift_o      shift value of the packet in flight
//     grant_o      index of the granted source
//     busy_o       a packet is in flight
//
//   Build option:
//     AXI4_SHIFT_ARB_SRC_TDEST_EN  when defined, pkt_o.tdest carries the
//                                  granted source index instead of the
//                                  source's own tdest.
// ---------------------------------------------------------------------------
module axi4_stream_shift_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 1,
    parameter int DEST_WIDTH     = 1,
    parameter int USER_WIDTH     = 1,
    parameter int NUM_SRC        = 4,
    parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
    parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B),
    parameter int SRC_W          = $clog2(NUM_SRC)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NUM_SRC-1:0][DATA_WIDTH_B_W-1:0]  shift_cfg_i,
    axi4_stream_if.slave                            pkt_i [NUM_SRC],
    axi4_stream_if.master                           pkt_o,
    output logic [DATA_WIDTH_B_W-1:0]               shift_o,
    output logic [SRC_W-1:0]                        grant_o,
    output logic                                    busy_o
);

    localparam int unsigned NUM_SRC_U = NUM_SRC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    generate
        if (NUM_SRC < 2) begin : g_chk_num_src
            $error("axi4_stream_shift_arbiter: NUM_SRC must be at least 2");
        end
    endgenerate

    // Index arithmetic that wraps at NUM_SRC even when it is not a power of two.
    function automatic logic [SRC_W-1:0] f_wrap_add(input logic [SRC_W-1:0] base,
                                                     input int unsigned       ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= NUM_SRC_U) begin
            sum = sum - NUM_SRC_U;
        end
        return SRC_W'(sum);
    endfunction

    function automatic logic [SRC_W-1:0] f_next_src(input logic [SRC_W-1:0] s);
        return (s == SRC_W'(NUM_SRC - 1)) ? '0 : s + SRC_W'(1);
    endfunction

    state_t                    r_state;
    state_t                    w_next_state;
    logic [SRC_W-1:0]          r_rr_ptr;
    logic [SRC_W-1:0]          r_grant;
    logic [DATA_WIDTH_B_W-1:0] r_shift;
    logic                      w_load;
    logic                      w_release;
    logic                      w_pass;
    logic [SRC_W-1:0]          w_pick;
    logic [SRC_W-1:0]          w_cand [NUM_SRC];

    // Source signals gathered into plain arrays so they can be muxed by a
    // run-time index (interface arrays only accept constant indices).
    logic [NUM_SRC-1:0]        w_src_tvalid;
    logic [NUM_SRC-1:0]        w_src_tlast;
    logic [DATA_WIDTH-1:0]     w_src_tdata [NUM_SRC];
    logic [DATA_WIDTH_B-1:0]   w_src_tkeep [NUM_SRC];
    logic [DATA_WIDTH_B-1:0]   w_src_tstrb [NUM_SRC];
    logic [ID_WIDTH-1:0]       w_src_tid   [NUM_SRC];
    logic [USER_WIDTH-1:0]     w_src_tuser [NUM_SRC];
`ifndef AXI4_SHIFT_ARB_SRC_TDEST_EN
    logic [DEST_WIDTH-1:0]     w_src_tdest [NUM_SRC];
`endif

    assign w_pass = (r_state == ST_PASS);

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            assign w_src_tvalid[g] = pkt_i[g].tvalid;
            assign w_src_tlast[g]  = pkt_i[g].tlast;
            assign w_src_tdata[g]  = pkt_i[g].tdata;
            assign w_src_tkeep[g]  = pkt_i[g].tkeep;
            assign w_src_tstrb[g]  = pkt_i[g].tstrb;
            assign w_src_tid[g]    = pkt_i[g].tid;
            assign w_src_tuser[g]  = pkt_i[g].tuser;
`ifndef AXI4_SHIFT_ARB_SRC_TDEST_EN
            assign w_src_tdest[g]  = pkt_i[g].tdest;
`endif
            // Only the granted source sees the downstream ready, and only in PASS.
            assign pkt_i[g].tready = w_pass && (r_grant == SRC_W'(g)) && pkt_o.tready;

            // Search order for this cycle: rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
            assign w_cand[g] = f_wrap_add(r_rr_ptr, g);
        end
    endgenerate

    // Lowest search position with a valid request wins.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_src_tvalid[w_cand[i]]) begin
                w_pick = w_cand[i];
            end
        end
    end

    // Output pass-through; payload is left unmasked, tvalid is gated.
    assign pkt_o.tvalid = w_pass && w_src_tvalid[r_grant];
    assign pkt_o.tdata  = w_src_tdata[r_grant];
    assign pkt_o.tkeep  = w_src_tkeep[r_grant];
    assign pkt_o.tstrb  = w_src_tstrb[r_grant];
    assign pkt_o.tlast  = w_src_tlast[r_grant];
    assign pkt_o.tid    = w_src_tid[r_grant];
    assign pkt_o.tuser  = w_src_tuser[r_grant];

`ifdef AXI4_SHIFT_ARB_SRC_TDEST_EN
    generate
        if (DEST_WIDTH < SRC_W) begin : g_chk_dest
            $error("axi4_stream_shift_arbiter: DEST_WIDTH must be >= SRC_W when tdest carries the source index");
        end
    endgenerate
    assign pkt_o.tdest = DEST_WIDTH'(r_grant);
`else
    assign pkt_o.tdest = w_src_tdest[r_grant];
`endif

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_src_tvalid) begin
                    w_next_state = ST_PASS;
                    w_load       = 1'b1;
                end
            end
            ST_PASS: begin
                if (pkt_o.tvalid && pkt_o.tready && pkt_o.tlast) begin
                    w_next_state = ST_IDLE;
                    w_release    = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_shift  <= '0;
        end else begin
            r_state <= w_next_state;
            // Grant and shift are captured once per packet and held until the next grant.
            if (w_load) begin
                r_grant <= w_pick;
                r_shift <= shift_cfg_i[w_pick];
            end
            if (w_release) begin
                r_rr_ptr <= f_next_src(r_grant);
            end
        end
    end

    assign grant_o = r_grant;
    assign shift_o = r_shift;
    assign busy_o  = w_pass;

endmodule

// File: tb/tb_axi4_stream_shift_arbiter.sv
module tb_axi4_stream_shift_arbiter;

    localparam int DW  = 64;
    localparam int DSW = 4;
    localparam int NS  = 4;

    typedef struct {
        logic       rst;
        logic       chk;
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] b;
        logic       ordy;
        logic       busy;
        logic [1:0] grant;
        logic [2:0] shift;
        logic       ov;
        logic [3:0] rdy;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [3:0][2:0]  tb_cfg;
    logic [3:0]       tb_v;
    logic [3:0]       tb_l;
    logic [7:0]       tb_beat;
    logic             tb_ordy;
    logic [3:0]       tb_rdy;
    logic [2:0]       shift_o;
    logic [1:0]       grant_o;
    logic             busy_o;
    logic [3:0]       src_dest [4];

    int n_chk;
    int n_fail;

    axi4_stream_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW)) src_if [NS] ();
    axi4_stream_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW)) out_if ();

    initial begin
        src_dest[0] = 4'h5;
        src_dest[1] = 4'h9;
        src_dest[2] = 4'hF;
        src_dest[3] = 4'hC;
    end

    generate
        for (genvar g = 0; g < NS; g++) begin : g_drv
            assign src_if[g].tvalid = tb_v[g];
            assign src_if[g].tlast  = tb_l[g];
            assign src_if[g].tdata  = {8'(g), 48'h0, tb_beat};
            assign src_if[g].tkeep  = '1;
            assign src_if[g].tstrb  = '1;
            assign src_if[g].tid    = '0;
            assign src_if[g].tdest  = src_dest[g];
            assign src_if[g].tuser  = 1'(g);
            assign tb_rdy[g]        = src_if[g].tready;
        end
    endgenerate
    assign out_if.tready = tb_ordy;

    axi4_stream_shift_arbiter #(
        .DATA_WIDTH (DW),
        .DEST_WIDTH (DSW),
        .NUM_SRC    (NS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .shift_cfg_i (tb_cfg),
        .pkt_i       (src_if),
        .pkt_o       (out_if),
        .shift_o     (shift_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_v, input logic chk, input logic [3:0] v,
                                input logic [3:0] l, input logic [7:0] b, input logic ordy,
                                input logic busy, input logic [1:0] grant, input logic [2:0] shift,
                                input logic ov, input logic [3:0] rdy);
        vec_t t;
        t.rst = rst_v; t.chk = chk; t.v = v; t.l = l; t.b = b; t.ordy = ordy;
        t.busy = busy; t.grant = grant; t.shift = shift; t.ov = ov; t.rdy = rdy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check before the rising edge.
    task automatic step(input string nm, input vec_t t);
        logic [3:0] exp_dest;
        @(negedge clk);
        rst     = t.rst;
        tb_v    = t.v;
        tb_l    = t.l;
        tb_beat = t.b;
        tb_ordy = t.ordy;
        #2;
        if (t.chk) begin
            chk({nm, " busy"},   64'(busy_o),        64'(t.busy));
            chk({nm, " grant"},  64'(grant_o),       64'(t.grant));
            chk({nm, " shift"},  64'(shift_o),       64'(t.shift));
            chk({nm, " tvalid"}, 64'(out_if.tvalid), 64'(t.ov));
            chk({nm, " tready"}, 64'(tb_rdy),        64'(t.rdy));
            if (t.ov) begin
`ifdef AXI4_SHIFT_ARB_SRC_TDEST_EN
                exp_dest = {2'b00, t.grant};
`else
                exp_dest = src_dest[t.grant];
`endif
                chk({nm, " tdata"}, out_if.tdata,       {6'h0, t.grant, 48'h0, t.b});
                chk({nm, " tlast"}, 64'(out_if.tlast),  64'(t.l[t.grant]));
                chk({nm, " tdest"}, 64'(out_if.tdest),  64'(exp_dest));
                chk({nm, " tuser"}, 64'(out_if.tuser),  64'(t.grant[0]));
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t R;
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        tb_v    = '0;
        tb_l    = '0;
        tb_beat = '0;
        tb_ordy = 1'b1;
        tb_cfg[0] = 3'd2;
        tb_cfg[1] = 3'd6;
        tb_cfg[2] = 3'd3;
        tb_cfg[3] = 3'd7;
        R = mk(1, 0, 4'b0000, 4'b0000, 8'd0, 1, 0, 2'd0, 3'd0, 0, 4'b0000);

        // Single source 2, 3-word packet, then sources 0 and 3 to expose rr_ptr=3.
        tbl.push_back(R);
        tbl.push_back(R);
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0000, 8'd0, 1, 0, 2'd0, 3'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0000, 8'd0, 1, 1, 2'd2, 3'd3, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0000, 8'd1, 1, 1, 2'd2, 3'd3, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0100, 8'd2, 1, 1, 2'd2, 3'd3, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 8'd0, 1, 0, 2'd2, 3'd3, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1001, 4'b1001, 8'd0, 1, 0, 2'd2, 3'd3, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1001, 4'b1001, 8'd0, 1, 1, 2'd3, 3'd7, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 8'd0, 1, 0, 2'd3, 3'd7, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 8'd0, 1, 1, 2'd0, 3'd2, 1, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 8'd0, 1, 0, 2'd0, 3'd2, 0, 4'b0000));

        // All sources continuously valid with 1-word packets, from reset.
        tbl.push_back(R);
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 0, 2'd0, 3'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 1, 2'd0, 3'd2, 1, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 0, 2'd0, 3'd2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 1, 2'd1, 3'd6, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 0, 2'd1, 3'd6, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 1, 2'd2, 3'd3, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 0, 2'd2, 3'd3, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 1, 2'd3, 3'd7, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 0, 2'd3, 3'd7, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 1, 2'd0, 3'd2, 1, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 0, 2'd0, 3'd2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 8'd0, 1, 1, 2'd1, 3'd6, 1, 4'b0010));

        // Source 1, 4 words, downstream stalls and a 2-cycle source gap.
        tbl.push_back(R);
        tbl.push_back(mk(0, 1, 4'b0010, 4'b0000, 8'd0, 1, 0, 2'd0, 3'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0111, 4'b0000, 8'd0, 1, 1, 2'd1, 3'd6, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b0111, 4'b0000, 8'd1, 0, 1, 2'd1, 3'd6, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0111, 4'b0000, 8'd1, 0, 1, 2'd1, 3'd6, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0111, 4'b0000, 8'd1, 1, 1, 2'd1, 3'd6, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0000, 8'd2, 1, 1, 2'd1, 3'd6, 0, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0000, 8'd2, 0, 1, 2'd1, 3'd6, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0111, 4'b0000, 8'd2, 1, 1, 2'd1, 3'd6, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b0111, 4'b0010, 8'd3, 0, 1, 2'd1, 3'd6, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0111, 4'b0010, 8'd3, 1, 1, 2'd1, 3'd6, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0100, 8'd0, 1, 0, 2'd1, 3'd6, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0100, 8'd0, 1, 1, 2'd2, 3'd3, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 8'd0, 1, 0, 2'd2, 3'd3, 0, 4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // shift_cfg_i change during a packet only affects the next grant.
        step("cfg_rst", R);
        step("cfg_a", mk(0, 1, 4'b0001, 4'b0000, 8'd0, 1, 0, 2'd0, 3'd0, 0, 4'b0000));
        step("cfg_b", mk(0, 1, 4'b0001, 4'b0000, 8'd0, 1, 1, 2'd0, 3'd2, 1, 4'b0001));
        tb_cfg[0] = 3'd5;
        step("cfg_c", mk(0, 1, 4'b0001, 4'b0001, 8'd1, 1, 1, 2'd0, 3'd2, 1, 4'b0001));
        step("cfg_d", mk(0, 1, 4'b0000, 4'b0000, 8'd0, 1, 0, 2'd0, 3'd2, 0, 4'b0000));
        step("cfg_e", mk(0, 1, 4'b0001, 4'b0001, 8'd0, 1, 0, 2'd0, 3'd2, 0, 4'b0000));
        step("cfg_f", mk(0, 1, 4'b0001, 4'b0001, 8'd0, 1, 1, 2'd0, 3'd5, 1, 4'b0001));

        // Reset in the middle of a source-3 packet, with rr_ptr left at 3 beforehand.
        step("mrst_a", mk(0, 1, 4'b0100, 4'b0100, 8'd0, 1, 0, 2'd0, 3'd5, 0, 4'b0000));
        step("mrst_b", mk(0, 1, 4'b0100, 4'b0100, 8'd0, 1, 1, 2'd2, 3'd3, 1, 4'b0100));
        step("mrst_c", mk(0, 1, 4'b1000, 4'b0000, 8'd0, 1, 0, 2'd2, 3'd3, 0, 4'b0000));
        step("mrst_d", mk(0, 1, 4'b1000, 4'b0000, 8'd0, 1, 1, 2'd3, 3'd7, 1, 4'b1000));
        step("mrst_e", mk(0, 1, 4'b1000, 4'b0000, 8'd1, 1, 1, 2'd3, 3'd7, 1, 4'b1000));
        step("mrst_f", mk(1, 0, 4'b1000, 4'b0000, 8'd2, 1, 1, 2'd3, 3'd7, 1, 4'b1000));
        step("mrst_g", mk(0, 1, 4'b1010, 4'b1010, 8'd0, 1, 0, 2'd0, 3'd0, 0, 4'b0000));
        step("mrst_h", mk(0, 1, 4'b1010, 4'b1010, 8'd0, 1, 1, 2'd1, 3'd6, 1, 4'b0010));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
